// File: rtl/step_pkg.sv
// Shared types and constants for the step move scheduler.
// Holds the scheduler state enum and the constant step-period lookup.
package step_pkg;

   localparam int unsigned LevelW   = 4;
   localparam int unsigned MinLevel = 1;

   typedef enum logic [2:0] {
      StIdle,
      StAccel,
      StCruise,
      StDecel,
      StSettle
   } state_e;

   // P(L) = base * (16 - L), built from a constant multiplier table.
   function automatic int unsigned period_of(input logic [LevelW-1:0] lvl,
                                             input int unsigned       base);
      int unsigned mult;
      case (lvl)
         4'd1:    mult = 15;
         4'd2:    mult = 14;
         4'd3:    mult = 13;
         4'd4:    mult = 12;
         4'd5:    mult = 11;
         4'd6:    mult = 10;
         4'd7:    mult = 9;
         4'd8:    mult = 8;
         4'd9:    mult = 7;
         4'd10:   mult = 6;
         4'd11:   mult = 5;
         4'd12:   mult = 4;
         4'd13:   mult = 3;
         4'd14:   mult = 2;
         4'd15:   mult = 1;
         default: mult = 15;
      endcase
      return base * mult;
   endfunction

endpackage

// File: rtl/step_period_timer.sv
// Loadable down-counter with a zero flag; times both step periods and the
// post-move settle interval.
module step_period_timer #(
   parameter int unsigned DIV_W = 24
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [DIV_W-1:0] load_val_i,
   output logic             zero_o
);

   logic [DIV_W-1:0] count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/step_move_scheduler.sv
// Move-level step scheduler: accepts a move command and emits step pulses
// with a linear accel/cruise/decel ramp, then settles and pulses done.
module step_move_scheduler
   import step_pkg::*;
#(
   parameter int unsigned BASE_PERIOD   = 50000,
   parameter int unsigned RAMP_STEPS    = 8,
   parameter int unsigned SETTLE_CYCLES = 100000,
   parameter int unsigned STEP_W        = 16,
   parameter int unsigned DIV_W         = 24
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [STEP_W-1:0] cmd_steps_i,
   input  logic              cmd_dir_i,
   input  logic [3:0]        cmd_speed_i,
   input  logic              abort_i,
   output logic              make_step_o,
   output logic              dir_out_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [3:0]        cur_level_o,
   output logic [STEP_W-1:0] steps_left_o
);

   localparam int unsigned CntW = $clog2(RAMP_STEPS + 1);
   localparam logic [CntW-1:0]   RampCnt   = CntW'(RAMP_STEPS);
   localparam logic [DIV_W-1:0]  SettleVal = DIV_W'(SETTLE_CYCLES - 1);
   localparam logic [LevelW-1:0] LvlMin    = LevelW'(MinLevel);

   state_e              state_q, state_d;
   logic                dir_q, dir_d;
   logic [STEP_W-1:0]   sl_q, sl_d;
   logic [STEP_W-1:0]   up_q, up_d;
   logic [LevelW-1:0]   lvl_q, lvl_d;
   logic [LevelW-1:0]   tgt_q, tgt_d;
   logic [CntW-1:0]     lvl_cnt_q, lvl_cnt_d, lvl_cnt_inc;
   logic                tmr_load, tmr_zero;
   logic [DIV_W-1:0]    tmr_val;

   step_period_timer #(
      .DIV_W (DIV_W)
   ) u_timer (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         dir_q     <= 1'b0;
         sl_q      <= '0;
         up_q      <= '0;
         lvl_q     <= '0;
         tgt_q     <= '0;
         lvl_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         sl_q      <= sl_d;
         up_q      <= up_d;
         lvl_q     <= lvl_d;
         tgt_q     <= tgt_d;
         lvl_cnt_q <= lvl_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      dir_d       = dir_q;
      sl_d        = sl_q;
      up_d        = up_q;
      lvl_d       = lvl_q;
      tgt_d       = tgt_q;
      lvl_cnt_d   = lvl_cnt_q;
      lvl_cnt_inc = lvl_cnt_q + 1'b1;
      tmr_load    = 1'b0;
      tmr_val     = '0;
      make_step_o = 1'b0;
      done_o      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid_i && !abort_i) begin
               dir_d     = cmd_dir_i;
               sl_d      = cmd_steps_i;
               tgt_d     = (cmd_speed_i == '0) ? LvlMin : cmd_speed_i;
               up_d      = '0;
               lvl_cnt_d = '0;
               tmr_load  = 1'b1;
               if (cmd_steps_i == '0) begin
                  state_d = StSettle;
                  lvl_d   = '0;
                  tmr_val = SettleVal;
               end else begin
                  state_d = (tgt_d == LvlMin) ? StCruise : StAccel;
                  lvl_d   = LvlMin;
                  tmr_val = DIV_W'(period_of(LvlMin, BASE_PERIOD) - 1);
               end
            end
         end
         StAccel, StCruise, StDecel: begin
            if (abort_i) begin
               state_d  = StSettle;
               lvl_d    = '0;
               tmr_load = 1'b1;
               tmr_val  = SettleVal;
            end else if (tmr_zero) begin
               make_step_o = 1'b1;
               sl_d        = sl_q - 1'b1;
               tmr_load    = 1'b1;
               if (sl_d == '0) begin
                  state_d = StSettle;
                  lvl_d   = '0;
                  tmr_val = SettleVal;
               end else begin
                  if (state_q == StAccel) up_d = up_q + 1'b1;
                  // Decel trigger wins over a level-up on the same step.
                  if (state_q != StDecel && sl_d <= up_d) begin
                     state_d   = StDecel;
                     lvl_cnt_d = '0;
                  end else if (state_q != StCruise) begin
                     if (lvl_cnt_inc == RampCnt) begin
                        lvl_cnt_d = '0;
                        if (state_q == StAccel) begin
                           lvl_d = lvl_q + 1'b1;
                           if (lvl_d == tgt_q) state_d = StCruise;
                        end else if (lvl_q > LvlMin) begin
                           lvl_d = lvl_q - 1'b1;
                        end
                     end else begin
                        lvl_cnt_d = lvl_cnt_inc;
                     end
                  end
                  tmr_val = DIV_W'(period_of(lvl_d, BASE_PERIOD) - 1);
               end
            end
         end
         StSettle: begin
            if (tmr_zero) begin
               done_o  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign cmd_ready_o  = (state_q == StIdle) && !abort_i;
   assign busy_o       = (state_q != StIdle) && !done_o;
   assign dir_out_o    = dir_q;
   assign cur_level_o  = lvl_q;
   assign steps_left_o = sl_q;

endmodule

// File: tb/tb_step_move_scheduler.sv
// Self-checking bench for step_move_scheduler: table-driven and random moves
// against a step-level profile model, plus reset/abort/ignored-command cases.
module tb_step_move_scheduler;

   localparam int unsigned BP = 4;
   localparam int unsigned RS = 2;
   localparam int unsigned SC = 3;
   localparam int unsigned SW = 16;
   localparam int unsigned DW = 24;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_dir = 1'b0;
   logic          abort = 1'b0;
   logic [SW-1:0] cmd_steps = '0;
   logic [3:0]    cmd_speed = '0;
   logic          cmd_ready, make_step, dir_out, busy, done;
   logic [3:0]    cur_level;
   logic [SW-1:0] steps_left;

   step_move_scheduler #(
      .BASE_PERIOD   (BP),
      .RAMP_STEPS    (RS),
      .SETTLE_CYCLES (SC),
      .STEP_W        (SW),
      .DIV_W         (DW)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .cmd_valid_i  (cmd_valid),
      .cmd_ready_o  (cmd_ready),
      .cmd_steps_i  (cmd_steps),
      .cmd_dir_i    (cmd_dir),
      .cmd_speed_i  (cmd_speed),
      .abort_i      (abort),
      .make_step_o  (make_step),
      .dir_out_o    (dir_out),
      .busy_o       (busy),
      .done_o       (done),
      .cur_level_o  (cur_level),
      .steps_left_o (steps_left)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pulses[$];
   int dones[$];
   int max_lvl = 0;
   int dir_bad = 0;
   int busy_bad = 0;
   logic exp_dir = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Event times are recorded as the index of the clock edge that consumes them.
   always @(negedge clk) begin
      if (make_step === 1'b1) pulses.push_back(cyc + 1);
      if (done === 1'b1) begin
         dones.push_back(cyc + 1);
         if (busy !== 1'b0) busy_bad++;
      end
      if (busy === 1'b1 && dir_out !== exp_dir) dir_bad++;
      if (int'(cur_level) > max_lvl) max_lvl = int'(cur_level);
   end

   typedef struct {
      int steps;
      int speed;
      bit dir;
      int exp_pulses;
      int exp_maxlvl;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      pulses.delete();
      dones.delete();
      max_lvl  = 0;
      dir_bad  = 0;
      busy_bad = 0;
   endtask

   // Profile from the ramp rules, one iteration per step; times are offsets
   // from the accept edge.
   function automatic void model(input int steps, input int speed,
                                 output int times[$], output int maxlvl);
      int tgt, lvl, t, up, n, left;
      bit rising, falling;
      times.delete();
      tgt     = (speed == 0) ? 1 : speed;
      lvl     = 1;
      t       = 0;
      up      = 0;
      n       = 0;
      rising  = (tgt > 1);
      falling = 1'b0;
      maxlvl  = 0;
      for (int k = 1; k <= steps; k++) begin
         t += int'(BP) * (16 - lvl);
         times.push_back(t);
         if (lvl > maxlvl) maxlvl = lvl;
         left = steps - k;
         if (left == 0) break;
         if (falling) begin
            n++;
            if (n == int'(RS)) begin
               n = 0;
               if (lvl > 1) lvl--;
            end
         end else begin
            if (rising) up++;
            if (left <= up) begin
               falling = 1'b1;
               rising  = 1'b0;
               n       = 0;
            end else if (rising) begin
               n++;
               if (n == int'(RS)) begin
                  n = 0;
                  lvl++;
                  if (lvl == tgt) rising = 1'b0;
               end
            end
         end
      end
   endfunction

   task automatic start(input int steps, input int speed, input bit dir, output int a);
      @(negedge clk);
      cmd_steps = SW'(steps);
      cmd_speed = 4'(speed);
      cmd_dir   = dir;
      cmd_valid = 1'b1;
      exp_dir   = dir;
      check("ready_before_accept", int'(cmd_ready), 1);
      @(posedge clk);
      #1;
      a = cyc;
      clear_mon();
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_pulses(input int n, input int limit);
      int i;
      for (i = 0; i < limit; i++) begin
         @(posedge clk);
         #1;
         if (pulses.size() >= n) break;
      end
      if (i == limit) check("pulse_wait_timeout", 0, 1);
   endtask

   task automatic wait_done(input int limit);
      int i;
      for (i = 0; i < limit; i++) begin
         @(posedge clk);
         #1;
         if (dones.size() > 0) break;
      end
      if (i == limit) check("done_wait_timeout", 0, 1);
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic finish_move(input string name, input int a, input int times[$],
                              input int exp_max);
      int n;
      int last;
      check({name, "_pulse_count"}, pulses.size(), times.size());
      n = (pulses.size() < times.size()) ? pulses.size() : times.size();
      for (int i = 0; i < n; i++) check({name, "_pulse_time"}, pulses[i] - a, times[i]);
      last = (times.size() == 0) ? 0 : times[times.size() - 1];
      check({name, "_done_count"}, dones.size(), 1);
      if (dones.size() > 0) check({name, "_done_time"}, dones[0] - a, last + int'(SC));
      check({name, "_dir_stable"}, dir_bad, 0);
      check({name, "_busy_with_done"}, busy_bad, 0);
      check({name, "_max_level"}, max_lvl, exp_max);
      check({name, "_steps_left"}, int'(steps_left), 0);
      check({name, "_idle_busy"}, int'(busy), 0);
      check({name, "_idle_level"}, int'(cur_level), 0);
   endtask

   task automatic run_move(input string name, input int steps, input int speed,
                           input bit dir, input int exp_max);
      int a;
      int times[$];
      int mlvl;
      model(steps, speed, times, mlvl);
      start(steps, speed, dir, a);
      wait_done(steps * 70 + 50);
      finish_move(name, a, times, (exp_max < 0) ? mlvl : exp_max);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_make_step"}, int'(make_step), 0);
      check({name, "_done"}, int'(done), 0);
      check({name, "_busy"}, int'(busy), 0);
      check({name, "_dir_out"}, int'(dir_out), 0);
      check({name, "_cur_level"}, int'(cur_level), 0);
      check({name, "_steps_left"}, int'(steps_left), 0);
   endtask

   initial begin
      vec_t vecs[5];
      int a;
      int e;
      int times[$];
      int mlvl;

      vecs[0] = '{steps: 20, speed: 3,  dir: 1'b1, exp_pulses: 20, exp_maxlvl: 3};
      vecs[1] = '{steps: 3,  speed: 15, dir: 1'b0, exp_pulses: 3,  exp_maxlvl: 1};
      vecs[2] = '{steps: 0,  speed: 0,  dir: 1'b1, exp_pulses: 0,  exp_maxlvl: 0};
      vecs[3] = '{steps: 5,  speed: 0,  dir: 1'b0, exp_pulses: 5,  exp_maxlvl: 1};
      vecs[4] = '{steps: 12, speed: 2,  dir: 1'b1, exp_pulses: 12, exp_maxlvl: 2};

      // Reset state
      #12;
      check_reset_outputs("por");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("por_cmd_ready", int'(cmd_ready), 1);

      // Table-driven moves
      for (int v = 0; v < 5; v++) begin
         model(vecs[v].steps, vecs[v].speed, times, mlvl);
         check("table_model_pulses", times.size(), vecs[v].exp_pulses);
         run_move($sformatf("vec%0d", v), vecs[v].steps, vecs[v].speed, vecs[v].dir,
                  vecs[v].exp_maxlvl);
      end

      // Reset in the middle of a move
      start(10, 3, 1'b1, a);
      repeat (30) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      clear_mon();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midreset_cmd_ready", int'(cmd_ready), 1);
      repeat (150) @(posedge clk);
      #1;
      check("midreset_no_pulses", pulses.size(), 0);
      check("midreset_busy", int'(busy), 0);

      // Abort after the fifth step of a 40-step move
      start(40, 3, 1'b0, a);
      wait_pulses(5, 400);
      @(negedge clk);
      abort = 1'b1;
      e = cyc + 1;
      #1;
      check("abort_busy_ready", int'(cmd_ready), 0);
      @(negedge clk);
      abort = 1'b0;
      wait_done(50);
      check("abort_pulse_count", pulses.size(), 5);
      check("abort_steps_left", int'(steps_left), 35);
      check("abort_done_count", dones.size(), 1);
      if (dones.size() > 0) check("abort_done_time", dones[0], e + int'(SC));
      check("abort_level", int'(cur_level), 0);
      check("abort_busy", int'(busy), 0);

      // Abort in IDLE blocks acceptance
      @(negedge clk);
      abort     = 1'b1;
      cmd_valid = 1'b1;
      cmd_steps = SW'(4);
      #1;
      check("idle_abort_ready", int'(cmd_ready), 0);
      @(posedge clk);
      #1;
      check("idle_abort_busy", int'(busy), 0);
      check("idle_abort_steps_left", int'(steps_left), 35);
      @(negedge clk);
      abort     = 1'b0;
      cmd_valid = 1'b0;

      // A command during a move is ignored
      model(8, 2, times, mlvl);
      start(8, 2, 1'b0, a);
      wait_pulses(2, 300);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_dir   = 1'b1;
      cmd_steps = SW'(99);
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      check("ignore_dir_out", int'(dir_out), 0);
      check("ignore_steps_left", int'(steps_left), 6);
      wait_done(700);
      finish_move("ignore", a, times, mlvl);

      // Random moves against the model
      for (int r = 0; r < 6; r++) begin
         run_move($sformatf("rand%0d", r), int'($urandom_range(0, 30)),
                  int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
